// File: rtl/qu_common.sv
// Shared Qu core types and defaults for pipeline control.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package qu_common;

    localparam int QU_PC_WIDTH           = 32;
    localparam int QU_RESET_HOLD_DEFAULT = 5;
    localparam int QU_WARMUP_DEFAULT     = 20;

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2,
        FLUSH  = 2'd3
    } qu_pipe_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        EXC  = 2'd1,
        BR   = 2'd2,
        JMP  = 2'd3
    } qu_redirect_cause_t;

    // Largest of three cycle counts; sizes the shared down-counter.
    function automatic int qu_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/qu_down_counter.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
// Latency: load/decrement visible one cycle after the edge; zero is combinational from the count.
// Backpressure: none; en simply pauses counting.
module qu_down_counter #(
    parameter int             W       = 4,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load has priority over decrement; the count holds once it reaches zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/qu_pipe_ctrl.sv
// Pipeline control: reset/warm-up sequencing, per-stage stall/flush, redirect PC override.
// Latency: stall and RUN schedule_en are combinational; flush/override registered, one cycle.
// Backpressure: a younger-stage stall request stalls every older stage; redirects win over stall.
module qu_pipe_ctrl
    import qu_common::*;
#(
    parameter int N_STAGES      = 4,
    parameter int PC_WIDTH      = QU_PC_WIDTH,
    parameter int RESET_HOLD    = QU_RESET_HOLD_DEFAULT,
    parameter int WARMUP_CYCLES = QU_WARMUP_DEFAULT,
    parameter int FLUSH_CYCLES  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic [N_STAGES-1:0] stage_stall_req,
    input  logic                branch,
    input  logic                jump,
    input  logic                exception,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                core_rst,
    output logic [N_STAGES-1:0] stage_stall,
    output logic [N_STAGES-1:0] stage_flush,
    output logic                pc_override_valid,
    output logic [PC_WIDTH-1:0] pc_override,
    output logic                schedule_en,
    output logic                busy,
    output qu_redirect_cause_t  redirect_cause
);

    localparam int CNT_MAX = qu_max3(RESET_HOLD, WARMUP_CYCLES, FLUSH_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Counts are loaded with (cycles - 1) where the state must last exactly
    // that many cycles; WARMUP loads the full value because it lasts one
    // cycle longer than its count (one cycle even when the count is zero).
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(RESET_HOLD - 1);
    localparam logic [CNT_W-1:0] WARM_LD  = CNT_W'(WARMUP_CYCLES);
    localparam logic [CNT_W-1:0] FLUSH_LD = CNT_W'(FLUSH_CYCLES - 1);

    qu_pipe_state_t     state;
    qu_redirect_cause_t cause_sel;
    logic               redirect_any;
    logic               cnt_load;
    logic               cnt_en;
    logic [CNT_W-1:0]   cnt_ld_val;
    logic               cnt_zero;
    logic               stall_acc;
    logic [N_STAGES-1:0] run_stall;

    assign redirect_any = exception | branch | jump;

    // Redirect cause priority: exception over branch over jump.
    always_comb begin
        cause_sel = JMP;
        if (exception) begin
            cause_sel = EXC;
        end else if (branch) begin
            cause_sel = BR;
        end
    end

    // One counter serves all timed states; it is reloaded on each state entry.
    always_comb begin
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        cnt_ld_val = FLUSH_LD;
        case (state)
            HOLD: begin
                if (cnt_zero) begin
                    cnt_load   = 1'b1;
                    cnt_ld_val = WARM_LD;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            WARMUP: cnt_en = 1'b1;
            RUN:    cnt_load = redirect_any;
            FLUSH: begin
                if (exception) begin
                    cnt_load = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: ;
        endcase
    end

    qu_down_counter #(
        .W       (CNT_W),
        .RST_VAL (HOLD_LD)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (cnt_ld_val),
        .zero     (cnt_zero)
    );

    // Suffix-OR of stall requests: a stall at stage j holds every stage i <= j.
    always_comb begin
        stall_acc = stall;
        run_stall = '0;
        for (int i = N_STAGES - 1; i >= 0; i--) begin
            stall_acc    = stall_acc | stage_stall_req[i];
            run_stall[i] = stall_acc;
        end
    end

    // Stall is all ones outside RUN/FLUSH; FLUSH clears it so flushes always land.
    always_comb begin
        case (state)
            RUN:     stage_stall = run_stall;
            FLUSH:   stage_stall = '0;
            default: stage_stall = '1;
        endcase
    end

    assign schedule_en = (state == RUN) & ~stall & ~stage_stall_req[N_STAGES-1];

    // Sequencer FSM with registered core_rst, flush, busy and PC override.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= HOLD;
            core_rst          <= 1'b1;
            stage_flush       <= '0;
            pc_override_valid <= 1'b0;
            pc_override       <= '0;
            busy              <= 1'b1;
            redirect_cause    <= NONE;
        end else begin
            pc_override_valid <= 1'b0;
            case (state)
                HOLD: begin
                    if (cnt_zero) begin
                        state    <= WARMUP;
                        core_rst <= 1'b0;
                    end
                end
                WARMUP: begin
                    if (cnt_zero) begin
                        state <= RUN;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    if (redirect_any) begin
                        state             <= FLUSH;
                        stage_flush       <= '1;
                        busy              <= 1'b1;
                        pc_override       <= redirect_pc;
                        pc_override_valid <= 1'b1;
                        redirect_cause    <= cause_sel;
                    end
                end
                FLUSH: begin
                    // Only an exception may preempt a flush in progress.
                    if (exception) begin
                        pc_override       <= redirect_pc;
                        pc_override_valid <= 1'b1;
                        redirect_cause    <= EXC;
                    end else if (cnt_zero) begin
                        state       <= RUN;
                        stage_flush <= '0;
                        busy        <= 1'b0;
                    end
                end
                default: state <= HOLD;
            endcase
        end
    end

endmodule

// File: tb/tb_qu_pipe_ctrl.sv
module tb_qu_pipe_ctrl;
    import qu_common::*;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [3:0]  stage_stall_req;
    logic        branch, jump, exception;
    logic [31:0] redirect_pc;

    logic        a_core_rst, b_core_rst;
    logic [3:0]  a_stall, b_stall, a_flush, b_flush;
    logic        a_valid, b_valid;
    logic [31:0] a_pc, b_pc;
    logic        a_sched, b_sched, a_busy, b_busy;
    qu_redirect_cause_t a_cause, b_cause;

    int checks;
    int errors;
    logic [31:0] qa[$];
    logic [31:0] qb[$];

    qu_pipe_ctrl dut_a (
        .clk(clk), .rst(rst), .stall(stall), .stage_stall_req(stage_stall_req),
        .branch(branch), .jump(jump), .exception(exception), .redirect_pc(redirect_pc),
        .core_rst(a_core_rst), .stage_stall(a_stall), .stage_flush(a_flush),
        .pc_override_valid(a_valid), .pc_override(a_pc), .schedule_en(a_sched),
        .busy(a_busy), .redirect_cause(a_cause)
    );

    qu_pipe_ctrl #(.FLUSH_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst), .stall(stall), .stage_stall_req(stage_stall_req),
        .branch(branch), .jump(jump), .exception(exception), .redirect_pc(redirect_pc),
        .core_rst(b_core_rst), .stage_stall(b_stall), .stage_flush(b_flush),
        .pc_override_valid(b_valid), .pc_override(b_pc), .schedule_en(b_sched),
        .busy(b_busy), .redirect_cause(b_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rst_vals(input string tag);
        chk({tag, " a_core_rst"}, a_core_rst, 1'b1);
        chk({tag, " b_core_rst"}, b_core_rst, 1'b1);
        chk({tag, " a_stall"}, a_stall, 4'hF);
        chk({tag, " b_stall"}, b_stall, 4'hF);
        chk({tag, " a_flush"}, a_flush, 4'h0);
        chk({tag, " b_flush"}, b_flush, 4'h0);
        chk({tag, " a_valid"}, a_valid, 1'b0);
        chk({tag, " b_valid"}, b_valid, 1'b0);
        chk({tag, " a_pc"}, a_pc, 32'h0);
        chk({tag, " b_pc"}, b_pc, 32'h0);
        chk({tag, " a_sched"}, a_sched, 1'b0);
        chk({tag, " b_sched"}, b_sched, 1'b0);
        chk({tag, " a_busy"}, a_busy, 1'b1);
        chk({tag, " b_busy"}, b_busy, 1'b1);
    endtask

    // rst low for three edges, then release and follow HOLD(5) + WARMUP(20+1) into RUN.
    task automatic boot(input string tag);
        repeat (3) @(posedge clk);
        #1;
        chk_rst_vals({tag, " in_reset"});
        rst = 1'b1;
        for (int e = 1; e <= 26; e++) begin
            tick();
            chk({tag, " a_core_rst"}, a_core_rst, (e < 5));
            chk({tag, " b_core_rst"}, b_core_rst, (e < 5));
            chk({tag, " a_sched"}, a_sched, (e >= 26));
            chk({tag, " b_sched"}, b_sched, (e >= 26));
            chk({tag, " a_stall"}, a_stall, (e >= 26) ? 4'h0 : 4'hF);
            chk({tag, " a_busy"}, a_busy, (e < 26));
            chk({tag, " a_flush"}, a_flush, 4'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        stall = 1'b0;
        stage_stall_req = 4'h0;
        branch = 1'b0;
        jump = 1'b0;
        exception = 1'b0;
        redirect_pc = 32'h0;

        // Monitor: every override pulse must match the oldest expected PC.
        fork
            forever begin
                @(negedge clk);
                if (rst && a_valid) begin
                    if (qa.size() == 0) chk("a_pulse_unexpected", a_pc, 32'hFFFF_FFFF);
                    else chk("a_pulse_pc", a_pc, qa.pop_front());
                end
                if (rst && b_valid) begin
                    if (qb.size() == 0) chk("b_pulse_unexpected", b_pc, 32'hFFFF_FFFF);
                    else chk("b_pulse_pc", b_pc, qb.pop_front());
                end
            end
        join_none

        boot("boot1");

        // Per-stage stall back-propagation, combinational in RUN.
        stage_stall_req = 4'b0100; #1;
        chk("req0100 a_stall", a_stall, 4'b0111);
        chk("req0100 a_sched", a_sched, 1'b1);
        stage_stall_req = 4'b1000; #1;
        chk("req1000 a_stall", a_stall, 4'b1111);
        chk("req1000 a_sched", a_sched, 1'b0);
        stage_stall_req = 4'b0001; #1;
        chk("req0001 b_stall", b_stall, 4'b0001);
        stage_stall_req = 4'b0000; stall = 1'b1; #1;
        chk("gstall a_stall", a_stall, 4'b1111);
        chk("gstall a_sched", a_sched, 1'b0);
        stall = 1'b0;

        // Branch redirect.
        branch = 1'b1; redirect_pc = 32'h100;
        qa.push_back(32'h100); qb.push_back(32'h100);
        tick();
        branch = 1'b0;
        chk("br a_flush", a_flush, 4'hF);
        chk("br a_pc", a_pc, 32'h100);
        chk("br a_busy", a_busy, 1'b1);
        chk("br a_sched", a_sched, 1'b0);
        chk("br a_cause", a_cause, BR);
        chk("br b_flush", b_flush, 4'hF);
        chk("br b_stall", b_stall, 4'h0);
        tick();
        chk("br+1 a_flush", a_flush, 4'h0);
        chk("br+1 a_busy", a_busy, 1'b0);
        chk("br+1 a_sched", a_sched, 1'b1);
        chk("br+1 b_flush", b_flush, 4'hF);
        tick();
        chk("br+2 b_flush", b_flush, 4'hF);
        tick();
        chk("br+3 b_flush", b_flush, 4'h0);
        chk("br+3 b_busy", b_busy, 1'b0);

        // Exception + branch + stall on the same edge: exception wins, flush beats stall.
        stall = 1'b1; exception = 1'b1; branch = 1'b1; redirect_pc = 32'h200; #1;
        chk("exc pre a_stall", a_stall, 4'hF);
        qa.push_back(32'h200); qb.push_back(32'h200);
        tick();
        exception = 1'b0; branch = 1'b0;
        chk("exc a_flush", a_flush, 4'hF);
        chk("exc a_stall", a_stall, 4'h0);
        chk("exc a_pc", a_pc, 32'h200);
        chk("exc a_cause", a_cause, EXC);
        chk("exc b_stall", b_stall, 4'h0);
        tick();
        chk("exc+1 a_stall", a_stall, 4'hF);
        chk("exc+1 a_flush", a_flush, 4'h0);
        stall = 1'b0; #1;
        chk("exc+1 a_stall_clr", a_stall, 4'h0);
        tick(); tick();
        chk("exc+3 b_flush", b_flush, 4'h0);

        // Exception restarting a 3-cycle flush; concurrent and later jumps ignored.
        exception = 1'b1; redirect_pc = 32'h280;
        qa.push_back(32'h280); qb.push_back(32'h280);
        tick();
        exception = 1'b0;
        chk("rex b_flush", b_flush, 4'hF);
        tick();
        chk("rex+1 a_flush", a_flush, 4'h0);
        chk("rex+1 b_flush", b_flush, 4'hF);
        exception = 1'b1; jump = 1'b1; redirect_pc = 32'h300;
        qa.push_back(32'h300); qb.push_back(32'h300);
        tick();
        exception = 1'b0; redirect_pc = 32'h400;
        chk("rex+2 b_flush", b_flush, 4'hF);
        chk("rex+2 b_pc", b_pc, 32'h300);
        chk("rex+2 a_pc", a_pc, 32'h300);
        chk("rex+2 b_cause", b_cause, EXC);
        tick();
        jump = 1'b0;
        chk("rex+3 b_flush", b_flush, 4'hF);
        chk("rex+3 b_pc", b_pc, 32'h300);
        chk("rex+3 a_flush", a_flush, 4'h0);
        chk("rex+3 a_pc", a_pc, 32'h300);
        tick();
        chk("rex+4 b_flush", b_flush, 4'hF);
        tick();
        chk("rex+5 b_flush", b_flush, 4'h0);
        chk("rex+5 b_busy", b_busy, 1'b0);

        // Reset mid-FLUSH: immediate return to reset values, then full boot again.
        exception = 1'b1; redirect_pc = 32'h500;
        qa.push_back(32'h500); qb.push_back(32'h500);
        tick();
        exception = 1'b0;
        chk("rstf b_flush", b_flush, 4'hF);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk_rst_vals("mid_flush_rst");
        boot("boot2");

        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qu_pipe_ctrl.md
# qu_pipe_ctrl

Parametrised pipeline control unit for the Qu core. It sequences core reset release and scheduler warm-up, and distributes per-stage stall and flush for an N-stage front end (IF/ID/MP/RN and successors). It arbitrates branch, jump and exception redirects into a registered PC override. It sits beside `qu_core` and replaces hand-driven stall, reset and `schedule_en` control.

## Interface
- `N_STAGES`, 4: number of front-end stages controlled; stage 0 is the oldest (IF), stage N_STAGES-1 the youngest.
- `PC_WIDTH`, `QU_PC_WIDTH`: width of the redirect PC.
- `RESET_HOLD`, 5: cycles `core_rst` stays high after `rst` deasserts; ≥1.
- `WARMUP_CYCLES`, 20: cycles between core reset release and `schedule_en` enable; ≥0.
- `FLUSH_CYCLES`, 1: cycles `stage_flush` is held per redirect; ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `stall` in 1: global stall request; stalls all stages.
- `stage_stall_req` in N_STAGES: per-stage stall request, e.g. downstream FIFO full.
- `branch`, `jump`, `exception` in 1 each: redirect requests, sampled at the rising edge.
- `redirect_pc` in PC_WIDTH: target PC accompanying a redirect.
- `core_rst` out 1: active-high synchronous reset to core stages.
- `stage_stall` out N_STAGES: effective per-stage stall.
- `stage_flush` out N_STAGES: per-stage flush.
- `pc_override_valid` out 1: one-cycle pulse marking a new override.
- `pc_override` out PC_WIDTH: registered redirect PC.
- `schedule_en` out 1: scheduler issue enable.
- `busy` out 1: high when the state is not RUN.

## Operation
- FSM `qu_pipe_state_t` has four states: HOLD, WARMUP, RUN, FLUSH.
- HOLD:
  - `core_rst`=1.
  - Counts RESET_HOLD cycles after `rst` deasserts, then moves to WARMUP.
- WARMUP:
  - `core_rst`=0.
  - Counts WARMUP_CYCLES, then moves to RUN. With WARMUP_CYCLES=0 it lasts exactly one cycle.
- RUN:
  - `stage_stall[i]` = `stall` | OR of `stage_stall_req[j]` for j≥i. A younger stall back-propagates to every older stage.
  - `schedule_en` = !`stall` & !`stage_stall_req[N_STAGES-1]`.
- Any redirect in RUN moves to FLUSH.
  - Cause priority: exception > branch > jump. `redirect_pc` is captured into `pc_override`. Cause is captured for debug only.
  - `pc_override_valid` pulses for the first FLUSH cycle.
- FLUSH:
  - `stage_flush` is all ones and `schedule_en`=0 for FLUSH_CYCLES, then the FSM returns to RUN.
  - A new exception during FLUSH restarts the count and recaptures the PC, with a new valid pulse.
  - Branch or jump during FLUSH is ignored.
- In HOLD and WARMUP:
  - `stage_stall` is all ones, `stage_flush` is all zeros and `schedule_en`=0.
  - Redirects are ignored.
- In FLUSH, `stage_stall` is all zeros: flush overrides stall.
- Counters are `$clog2(max+1)` bits wide, load on state entry and count down to zero. They never wrap.

## Timing
- While `rst`=0, independent of `clk`: state=HOLD, `core_rst`=1, `stage_stall`=all ones, `stage_flush`=0, `pc_override_valid`=0, `pc_override`=0, `schedule_en`=0, `busy`=1.
- After the first rising edge with `rst`=1, `core_rst` stays high for exactly RESET_HOLD edges.
- `schedule_en` first rises RESET_HOLD+WARMUP_CYCLES+1 edges after `rst` deasserts, absent stall.
- A redirect sampled at edge k produces `stage_flush`, `pc_override` and `pc_override_valid` valid after edge k. They are registered with one cycle latency.
- `stage_stall` and the RUN-state `schedule_en` are combinational from the stall inputs, with zero latency.
- Simultaneous redirect and stall in RUN: the redirect is taken.
- `rst` asserted in any state, including mid-FLUSH: immediate return to reset values. The captured PC is cleared.

## Structure
- `qu_common` adds:
  - `typedef enum logic [1:0] qu_pipe_state_t` with states HOLD, WARMUP, RUN, FLUSH.
  - `typedef enum logic [1:0] qu_redirect_cause_t` with values NONE, EXC, BR, JMP.
  - Constants `QU_RESET_HOLD_DEFAULT` and `QU_WARMUP_DEFAULT`.
- One sub-module, `qu_down_counter`: parametrised width, load/enable, `zero` flag, async active-low reset. It is shared by the HOLD, WARMUP and FLUSH counts.

## Test plan
- Defaults, `rst` low for 3 cycles then high → `core_rst` high for 5 more edges. `schedule_en` rises at edge 26 after release. `stage_stall` is 4'b1111 until RUN, then 4'b0000.
- RUN, `stage_stall_req`=4'b0100 → `stage_stall`=4'b0111 in the same cycle, `schedule_en` stays 1. `stage_stall_req`=4'b1000 → 4'b1111, `schedule_en`=0.
- RUN, branch with `redirect_pc`=0x100 → next cycle `pc_override`=0x100, `pc_override_valid`=1 for one cycle, `stage_flush`=4'b1111 for 1 cycle, then RUN.
- Same edge: exception (`redirect_pc`=0x200) with branch and `stall`=1 → `pc_override`=0x200, flush taken, `stage_stall`=0 during FLUSH.
- FLUSH_CYCLES=3, exception in the 2nd flush cycle with PC 0x300 → flush extends to 3 cycles from the new edge, a second valid pulse, `pc_override`=0x300. A concurrent jump is ignored.
- `rst` pulsed low mid-FLUSH → all outputs at reset values immediately. The full HOLD/WARMUP sequence repeats.
